pb_bus_arbiter: RTL and testbench
=================================

# pb_bus_arbiter

Round-robin arbiter that shares the lamp-card parallel bus (data port, address port, BOARD_X select, RdP/WrP strobes, data direction) among several bus-cycle state machines: the UART command sub-machines, the lamp-card reset sequencer and a future background ADC poller. It grants exclusive ownership to one requester at a time. It enforces an idle turnaround between owners so the data-port direction never flips under a live strobe. An optional watchdog forcibly revokes a grant held too long.

## Interface
- NUM_REQ, 3: number of requesters, legal range 2..8.
- TURNAROUND_CYCLES, 4: idle cycles between a release and the next grant, legal range 0..255.
- TIMEOUT_CYCLES, 2700: maximum grant length in clock cycles, equal to 100 us at 27 MHz; legal range 1..65535.
- clock  in  1  system clock, 27 MHz.
- reset_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  level request; the requester holds it high for the whole bus transaction.
- grant  out  NUM_REQ  one-hot ownership, or all zero.
- grant_id  out  ID_W  index of the current owner, where ID_W = $clog2(NUM_REQ); holds its last value when no grant is active.
- bus_busy  out  1  high in GRANT and TURNAROUND; the top level forces data_dir to input while this is low.
- timeout_pulse  out  1  one-cycle strobe when the watchdog revokes a grant.
- timeout_id  out  ID_W  index of the revoked requester; valid with timeout_pulse, held afterwards.
- lockout  out  NUM_REQ  requesters barred after a timeout.

## Operation
- States: IDLE, GRANT, TURNAROUND.
- IDLE transitions:
  - If (req & ~lockout) is nonzero, pick the first eligible index searching upward from last_owner+1, modulo NUM_REQ.
  - Set grant, grant_id and last_owner, then go to GRANT.
- GRANT transitions:
  - While req[grant_id] is high, hold the grant.
  - When req[grant_id] is low, clear grant. Go to TURNAROUND, or to IDLE if TURNAROUND_CYCLES == 0.
- TURNAROUND transitions:
  - Count TURNAROUND_CYCLES cycles with grant = 0 and bus_busy = 1, then go to IDLE.
  - Requests arriving during TURNAROUND wait; they are not queued beyond the level req.
- Fairness: a requester that just released cannot win again while any other eligible requester is asserting req.
- Lockout:
  - A timeout sets lockout[owner].
  - That bit clears on the first cycle in which req[owner] is sampled low.
  - A locked requester is never granted.
- Other req bits changing during GRANT have no effect.
- Reset values:
  - grant = 0, grant_id = 0, bus_busy = 0, timeout_pulse = 0, timeout_id = 0, lockout = 0.
  - State = IDLE; last_owner = NUM_REQ-1, so req[0] wins the first arbitration.
- Reset mid-transaction: grant drops asynchronously with no turnaround. Top-level strobes must be gated by grant.

## Timing
- req sampled high in IDLE at edge N gives grant high after edge N+1: one-cycle latency.
- req sampled low in GRANT at edge N gives grant low after edge N+1.
- Next grant after a release: earliest at edge N+2+TURNAROUND_CYCLES.
- Watchdog counter:
  - Width $clog2(TIMEOUT_CYCLES+1). Cleared on entry to GRANT; increments each GRANT cycle.
  - At count == TIMEOUT_CYCLES-1 with req still high: grant clears next edge, timeout_pulse is high for exactly that cycle, then TURNAROUND.
- Release and timeout in the same cycle: treated as a normal release; no timeout_pulse, no lockout.
- All outputs are registered; no combinational path from req to grant.

## Configuration
- PB_ARB_TIMEOUT_EN defined: watchdog, lockout, timeout_pulse and timeout_id are implemented as above.
- PB_ARB_TIMEOUT_EN not defined:
  - No counter is built; grants are unbounded.
  - timeout_pulse, timeout_id and lockout are tied to 0.
  - The TIMEOUT_CYCLES parameter remains declared but has no effect.

## Structure
- Shared package pb_bus_pkg holds:
  - typedef arb_state_t {ARB_IDLE, ARB_GRANT, ARB_TURNAROUND}.
  - Constants PB_REQ_CMD = 0, PB_REQ_RESET = 1, PB_REQ_POLL = 2, used by the top level to index req and grant.
- Sub-module pb_rr_picker: purely combinational. Inputs are the eligible vector and last_owner; outputs are a found flag and the winner index. It is reused by any later multi-requester block.

## Test plan
- Single request: req = 3'b001 at reset exit, so grant = 3'b001 one cycle later. Drop req, so grant = 0 next cycle, bus_busy stays high 4 cycles, then falls.
- Contention: req = 3'b111 held continuously with each owner releasing after 10 cycles gives grant order 0, 1, 2, 0, separated by exactly 4 idle cycles.
- Timeout (macro on, TIMEOUT_CYCLES = 20): requester 1 holds req 50 cycles, so grant[1] drops after cycle 20 with timeout_pulse = 1 and timeout_id = 1. It is not regranted until req[1] has been low for at least one cycle.
- Release on the timeout boundary: req drops at count 19 gives no timeout_pulse and lockout = 0.
- Reset mid-grant: reset_n low during an active grant makes grant = 0 and bus_busy = 0 immediately. After release of reset, req = 3'b110 gives grant = 3'b010.
- Macro off: a 100k-cycle grant is never revoked, and timeout_pulse stays 0.

Source files
------------

// File: rtl/pb_bus_pkg.sv
// Shared types and constants for the lamp-card parallel bus arbiter and its clients.
package pb_bus_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE       = 2'd0,
      ARB_GRANT      = 2'd1,
      ARB_TURNAROUND = 2'd2
   } arb_state_t;

   // Requester slots on the lamp-card bus, used to index req and grant.
   localparam int PB_REQ_CMD   = 0;
   localparam int PB_REQ_RESET = 1;
   localparam int PB_REQ_POLL  = 2;

   // Turnaround counter width; covers the full 0..255 turnaround range.
   localparam int PB_TA_W = 8;

endpackage

// File: rtl/pb_bus_arbiter_if.sv
// Request/grant bundle between the bus-cycle state machines and the bus arbiter.
interface pb_bus_arbiter_if
   import pb_bus_pkg::*;
#(
   parameter int NUM_REQ = 3
) ();

   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] grant;
   logic [ID_W-1:0]    grant_id;
   logic               bus_busy;
   logic               timeout_pulse;
   logic [ID_W-1:0]    timeout_id;
   logic [NUM_REQ-1:0] lockout;

   modport master (
      output req,
      input  grant,
      input  grant_id,
      input  bus_busy,
      input  timeout_pulse,
      input  timeout_id,
      input  lockout
   );

   modport slave (
      input  req,
      output grant,
      output grant_id,
      output bus_busy,
      output timeout_pulse,
      output timeout_id,
      output lockout
   );

endinterface

// File: rtl/pb_rr_picker.sv
// Combinational round-robin picker: first set bit of eligible searching upward
// from last_owner+1, wrapping modulo NUM_REQ.
module pb_rr_picker
   import pb_bus_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [ID_W-1:0]    last_owner,
   output logic               found,
   output logic [ID_W-1:0]    winner
);

   int cand;

   // Walk offsets from farthest to nearest so the nearest eligible index wins.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = 0;
      for (int off = NUM_REQ; off >= 1; off--) begin
         cand = (int'(last_owner) + off) % NUM_REQ;
         if (eligible[ID_W'(cand)]) begin
            found  = 1'b1;
            winner = ID_W'(cand);
         end
      end
   end

endmodule

// File: rtl/pb_bus_arbiter.sv
// Round-robin owner arbitration for the shared lamp-card parallel bus with idle turnaround.
// Define PB_ARB_TIMEOUT_EN to build the grant watchdog, lockout and timeout reporting.
module pb_bus_arbiter
   import pb_bus_pkg::*;
#(
   parameter int NUM_REQ           = 3,
   parameter int TURNAROUND_CYCLES = 4,
   parameter int TIMEOUT_CYCLES    = 2700
) (
   input  logic            clock,
   input  logic            reset_n,
   pb_bus_arbiter_if.slave bus
);

   localparam int                ID_W      = $clog2(NUM_REQ);
   localparam logic [ID_W-1:0]   LAST_INIT = ID_W'(NUM_REQ - 1);
   localparam logic [PB_TA_W-1:0] TA_LOAD  =
      (TURNAROUND_CYCLES == 0) ? '0 : PB_TA_W'(TURNAROUND_CYCLES - 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 ||
       TURNAROUND_CYCLES < 0 || TURNAROUND_CYCLES > 255 ||
       TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
      $error("pb_bus_arbiter: parameter outside its legal range");
   end

   arb_state_t          state_q, state_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic [ID_W-1:0]     last_owner_q, last_owner_d;
   logic                bus_busy_q, bus_busy_d;
   logic [PB_TA_W-1:0]  ta_cnt_q, ta_cnt_d;

   logic [NUM_REQ-1:0]  eligible;
   logic                pick_found;
   logic [ID_W-1:0]     pick_winner;
   logic                rel_now;

`ifdef PB_ARB_TIMEOUT_EN
   localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

   logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
   logic                timeout_pulse_q, timeout_pulse_d;
   logic [ID_W-1:0]     timeout_id_q, timeout_id_d;
   logic [NUM_REQ-1:0]  lockout_q, lockout_d;

   assign eligible = bus.req & ~lockout_q;
`else
   assign eligible = bus.req;
`endif

   pb_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .eligible   (eligible),
      .last_owner (last_owner_q),
      .found      (pick_found),
      .winner     (pick_winner)
   );

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      grant_id_d   = grant_id_q;
      last_owner_d = last_owner_q;
      bus_busy_d   = bus_busy_q;
      ta_cnt_d     = ta_cnt_q;
      rel_now      = 1'b0;
`ifdef PB_ARB_TIMEOUT_EN
      wd_cnt_d        = wd_cnt_q;
      timeout_pulse_d = 1'b0;
      timeout_id_d    = timeout_id_q;
      // A lockout bit lifts as soon as its requester is seen idle.
      lockout_d       = lockout_q & bus.req;
`endif

      case (state_q)
         ARB_IDLE: begin
            if (pick_found) begin
               state_d      = ARB_GRANT;
               grant_d      = NUM_REQ'(1) << pick_winner;
               grant_id_d   = pick_winner;
               last_owner_d = pick_winner;
               bus_busy_d   = 1'b1;
`ifdef PB_ARB_TIMEOUT_EN
               wd_cnt_d     = '0;
`endif
            end
         end

         ARB_GRANT: begin
            if (!bus.req[grant_id_q]) begin
               rel_now = 1'b1;
            end
`ifdef PB_ARB_TIMEOUT_EN
            else if (wd_cnt_q == WD_MAX) begin
               rel_now                = 1'b1;
               timeout_pulse_d        = 1'b1;
               timeout_id_d           = grant_id_q;
               lockout_d[grant_id_q]  = 1'b1;
            end else begin
               wd_cnt_d = wd_cnt_q + WD_W'(1);
            end
`endif
         end

         ARB_TURNAROUND: begin
            if (ta_cnt_q == '0) begin
               state_d    = ARB_IDLE;
               bus_busy_d = 1'b0;
            end else begin
               ta_cnt_d = ta_cnt_q - PB_TA_W'(1);
            end
         end

         default: begin
            state_d    = ARB_IDLE;
            grant_d    = '0;
            bus_busy_d = 1'b0;
         end
      endcase

      // Release and revocation share the exit path; a zero turnaround skips straight to IDLE.
      if (rel_now) begin
         grant_d = '0;
         if (TURNAROUND_CYCLES == 0) begin
            state_d    = ARB_IDLE;
            bus_busy_d = 1'b0;
         end else begin
            state_d  = ARB_TURNAROUND;
            ta_cnt_d = TA_LOAD;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q         <= ARB_IDLE;
         grant_q         <= '0;
         grant_id_q      <= '0;
         last_owner_q    <= LAST_INIT;
         bus_busy_q      <= 1'b0;
         ta_cnt_q        <= '0;
`ifdef PB_ARB_TIMEOUT_EN
         wd_cnt_q        <= '0;
         timeout_pulse_q <= 1'b0;
         timeout_id_q    <= '0;
         lockout_q       <= '0;
`endif
      end else begin
         state_q         <= state_d;
         grant_q         <= grant_d;
         grant_id_q      <= grant_id_d;
         last_owner_q    <= last_owner_d;
         bus_busy_q      <= bus_busy_d;
         ta_cnt_q        <= ta_cnt_d;
`ifdef PB_ARB_TIMEOUT_EN
         wd_cnt_q        <= wd_cnt_d;
         timeout_pulse_q <= timeout_pulse_d;
         timeout_id_q    <= timeout_id_d;
         lockout_q       <= lockout_d;
`endif
      end
   end

   assign bus.grant    = grant_q;
   assign bus.grant_id = grant_id_q;
   assign bus.bus_busy = bus_busy_q;

`ifdef PB_ARB_TIMEOUT_EN
   assign bus.timeout_pulse = timeout_pulse_q;
   assign bus.timeout_id    = timeout_id_q;
   assign bus.lockout       = lockout_q;
`else
   assign bus.timeout_pulse = 1'b0;
   assign bus.timeout_id    = '0;
   assign bus.lockout       = '0;
`endif

endmodule

// File: tb/tb_pb_bus_arbiter.sv
// Bench for pb_bus_arbiter: requester agents drive req, a timeline model predicts outputs,
// and a negedge monitor compares the DUT against the predicted stream.
module tb_pb_bus_arbiter;
   import pb_bus_pkg::*;

   localparam int N  = 3;
   localparam int T  = 4;
   localparam int TO = 20;
`ifdef PB_ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic clock   = 1'b0;
   logic reset_n = 1'b1;

   pb_bus_arbiter_if #(.NUM_REQ(N)) bus ();

   pb_bus_arbiter #(
      .NUM_REQ           (N),
      .TURNAROUND_CYCLES (T),
      .TIMEOUT_CYCLES    (TO)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial forever #5 clock = ~clock;

   typedef struct packed {
      logic [2:0] grant;
      logic [1:0] gid;
      logic       busy;
      logic       pulse;
      logic [1:0] tid;
      logic [2:0] lock;
   } obs_t;

   obs_t exp_q[$];
   int   cyc_q[$];
   int   order_q[$];
   int   errors = 0;
   int   checks = 0;
   int   pulses = 0;

   // Timeline model: owner index (-1 none), grant start edge, first edge arbitration may resume.
   int         m_k = 0;
   int         m_owner, m_start, m_avail, m_last;
   logic [2:0] m_lock;
   logic [1:0] m_gid, m_tid;
   logic       m_pulse;

   // Requester agents
   logic [2:0] req_drv;
   int         a_len[3], a_age[3], a_gap[3], a_gapmax[3];
   bit         a_got[3];
   int         jobs[3][$];

   function automatic obs_t dut_obs();
      obs_t o;
      o.grant = bus.grant;
      o.gid   = bus.grant_id;
      o.busy  = bus.bus_busy;
      o.pulse = bus.timeout_pulse;
      o.tid   = bus.timeout_id;
      o.lock  = bus.lockout;
      return o;
   endfunction

   task automatic check_obs(input string name, input int cyc, input obs_t act, input obs_t exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d actual grant=%b id=%0d busy=%b pulse=%b tid=%0d lock=%b required grant=%b id=%0d busy=%b pulse=%b tid=%0d lock=%b",
                  name, cyc, act.grant, act.gid, act.busy, act.pulse, act.tid, act.lock,
                  exp.grant, exp.gid, exp.busy, exp.pulse, exp.tid, exp.lock);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_start = 0;
      m_avail = 0;
      m_last  = N - 1;
      m_lock  = '0;
      m_gid   = '0;
      m_tid   = '0;
      m_pulse = 1'b0;
   endtask

   task automatic agents_reset();
      req_drv = '0;
      for (int i = 0; i < N; i++) begin
         a_len[i] = 0;
         a_age[i] = 0;
         a_gap[i] = 0;
         a_gapmax[i] = 0;
         a_got[i] = 1'b0;
         jobs[i].delete();
      end
   endtask

   // Advance the model by one clock edge with r the req value sampled there.
   task automatic model_step(input logic [2:0] r);
      logic [2:0] lock_old, elig;
      int c;
      obs_t e;
      m_k++;
      m_pulse  = 1'b0;
      lock_old = m_lock;
      m_lock   = m_lock & r;
      if (m_owner >= 0) begin
         if (!r[2'(m_owner)]) begin
            m_owner = -1;
            m_avail = m_k + T + 1;
         end else if (TO_EN && (m_k - m_start == TO)) begin
            m_pulse = 1'b1;
            m_tid   = 2'(m_owner);
            m_lock[2'(m_owner)] = 1'b1;
            m_owner = -1;
            m_avail = m_k + T + 1;
         end
      end else if (m_k >= m_avail) begin
         elig = r & ~lock_old;
         for (int off = 1; off <= N; off++) begin
            c = (m_last + off) % N;
            if (m_owner < 0 && elig[2'(c)]) begin
               m_owner = c;
               m_start = m_k;
               m_last  = c;
               m_gid   = 2'(c);
            end
         end
      end
      e.grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
      e.gid   = m_gid;
      e.busy  = (m_owner >= 0) || (m_k < m_avail - 1);
      e.pulse = m_pulse;
      e.tid   = m_tid;
      e.lock  = m_lock;
      exp_q.push_back(e);
      cyc_q.push_back(m_k);
   endtask

   // Each agent holds req for a_len cycles counted from its first grant, then drops it.
   task automatic agents_update();
      for (int i = 0; i < N; i++) begin
         if (req_drv[i]) begin
            if (m_owner == i) a_got[i] = 1'b1;
            if (a_got[i]) begin
               a_age[i]++;
               if (a_age[i] >= a_len[i]) begin
                  req_drv[i] = 1'b0;
                  a_got[i]   = 1'b0;
                  a_age[i]   = 0;
                  a_gap[i]   = (a_gapmax[i] > 0) ? int'($urandom_range(0, a_gapmax[i])) : 0;
               end
            end
         end else if (jobs[i].size() > 0) begin
            if (a_gap[i] > 0) a_gap[i]--;
            else begin
               a_len[i]   = jobs[i].pop_front();
               req_drv[i] = 1'b1;
            end
         end
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      model_step(req_drv);
      agents_update();
      #1 bus.req = req_drv;
   endtask

   function automatic bit all_idle();
      return jobs[0].size() == 0 && jobs[1].size() == 0 && jobs[2].size() == 0 &&
             req_drv == 3'b000 && m_owner < 0 && m_k >= m_avail;
   endfunction

   task automatic run_phase(input string name, input int max_cyc);
      int n = 0;
      bit done = 1'b0;
      while (!done && n < max_cyc) begin
         cycle();
         n++;
         done = all_idle();
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL %s phase incomplete after %0d cycles", name, max_cyc);
      end
   endtask

   // Reset asserted just after the monitor has sampled, so no prediction is pending.
   task automatic assert_reset(input string name);
      @(negedge clock);
      #1 reset_n = 1'b0;
      #1 check_obs(name, m_k, dut_obs(), '0);
      model_reset();
      agents_reset();
      exp_q.delete();
      cyc_q.delete();
   endtask

   task automatic release_reset();
      bus.req = req_drv;
      @(posedge clock);
      @(posedge clock);
      #1 reset_n = 1'b1;
   endtask

   // Monitor: compares every predicted cycle and records grant order and timeout strobes.
   initial begin
      obs_t e, a;
      int k;
      logic [2:0] prev_grant = '0;
      forever begin
         @(negedge clock);
         a = dut_obs();
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            k = cyc_q.pop_front();
            check_obs("cycle", k, a, e);
         end
         if (a.pulse === 1'b1) pulses++;
         if (a.grant != 3'b000 && prev_grant == 3'b000) order_q.push_back(int'(a.gid));
         prev_grant = a.grant;
      end
   end

   initial begin
      bus.req = '0;
      agents_reset();
      model_reset();
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clock);
      #1 check_obs("reset_state", 0, dut_obs(), '0);

      // Single requester present at reset exit
      req_drv[PB_REQ_CMD] = 1'b1;
      a_len[PB_REQ_CMD]   = 6;
      bus.req = req_drv;
      reset_n = 1'b1;
      run_phase("single", 60);

      // Full contention from a fresh reset: expect owners 0,1,2,0
      assert_reset("reset_idle");
      release_reset();
      order_q.delete();
      jobs[0].push_back(10);
      jobs[0].push_back(10);
      jobs[1].push_back(10);
      jobs[2].push_back(10);
      run_phase("contention", 200);
      check_int("order_len", order_q.size(), 4);
      if (order_q.size() == 4) begin
         check_int("order0", order_q[0], 0);
         check_int("order1", order_q[1], 1);
         check_int("order2", order_q[2], 2);
         check_int("order3", order_q[3], 0);
      end

      // Long holds and release right at / around the watchdog limit
      pulses = 0;
      jobs[PB_REQ_RESET].push_back(50);
      run_phase("hold50", 200);
      jobs[PB_REQ_CMD].push_back(20);
      run_phase("hold20", 100);
      jobs[PB_REQ_CMD].push_back(21);
      run_phase("hold21", 100);
      jobs[PB_REQ_POLL].push_back(19);
      run_phase("hold19", 100);
      jobs[PB_REQ_CMD].push_back(3000);
      run_phase("hold3000", 3200);
      check_int("timeout_count", pulses, TO_EN ? 3 : 0);

      // Reset in the middle of an active grant
      jobs[PB_REQ_CMD].push_back(40);
      for (int i = 0; i < 30 && !(m_owner == 0 && m_k - m_start >= 5); i++) cycle();
      check_int("grant_before_reset", int'(bus.grant), 1);
      assert_reset("reset_mid_grant");
      req_drv = 3'b110;
      a_len[1] = 5;
      a_len[2] = 5;
      release_reset();
      cycle();
      check_int("post_reset_grant", int'(bus.grant), 2);
      run_phase("post_reset", 100);

      // Randomised traffic
      for (int i = 0; i < N; i++) begin
         a_gapmax[i] = int'($urandom_range(0, 8));
         for (int j = 0; j < 15; j++) jobs[i].push_back(int'($urandom_range(1, 30)));
      end
      run_phase("random", 4000);

      repeat (2) @(negedge clock);
      #1 check_int("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
